// File: rtl/acc_controller.sv
// Sequencer for the 8-bit accumulator datapath: clear, load word count N, then accumulate N words.
// Outputs are a combinational decode of the state; an input-wait counter aborts stalled jobs into ERR.
module acc_controller #(
   parameter int unsigned WAIT_LIMIT = 255
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Start,
   input  logic       In_Valid,
   input  logic       Count_Reg_judge,
   output logic       In_Ready,
   output logic [4:0] ACC_Ctrl,
   output logic       Busy,
   output logic       Done,
   output logic       Error
);

   localparam int unsigned WW = (WAIT_LIMIT == 0) ? 1 : $clog2(WAIT_LIMIT + 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);

   localparam logic [4:0] CTRL_HOLD  = 5'b11000;
   localparam logic [4:0] CTRL_CLR   = 5'b00000;
   localparam logic [4:0] CTRL_LOADN = 5'b10110;
   localparam logic [4:0] CTRL_ACCUM = 5'b01111;
   localparam logic [4:0] CTRL_DECR  = 5'b10100;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_LOAD  = 3'd2,
      S_CHECK = 3'd3,
      S_ACC   = 3'd4,
      S_DEC   = 3'd5,
      S_DONE  = 3'd6,
      S_ERR   = 3'd7
   } state_t;

   state_t        state_q, state_d;
   logic [WW-1:0] wait_q, wait_d;
   logic          stall_s;
   logic [4:0]    ctrl_s;
   logic          rdy_s, busy_s, done_s, err_s;

   // State and wait-counter registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_IDLE;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // Next-state and control-word decode
   always_comb begin
      state_d = state_q;
      wait_d  = '0;
      stall_s = 1'b0;
      ctrl_s  = CTRL_HOLD;
      rdy_s   = 1'b0;
      busy_s  = 1'b0;
      done_s  = 1'b0;
      err_s   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (Start) state_d = S_CLEAR;
            else       state_d = S_IDLE;
         end
         S_CLEAR: begin
            busy_s  = 1'b1;
            ctrl_s  = CTRL_CLR;
            state_d = S_LOAD;
         end
         S_LOAD: begin
            busy_s = 1'b1;
            rdy_s  = 1'b1;
            if (In_Valid) begin
               ctrl_s  = CTRL_LOADN;
               state_d = S_CHECK;
            end else begin
               stall_s = 1'b1;
            end
         end
         S_CHECK: begin
            busy_s = 1'b1;
            if (Count_Reg_judge) state_d = S_ACC;
            else                 state_d = S_DONE;
         end
         S_ACC: begin
            busy_s = 1'b1;
            rdy_s  = 1'b1;
            if (In_Valid) begin
               ctrl_s  = CTRL_ACCUM;
               state_d = S_DEC;
            end else begin
               stall_s = 1'b1;
            end
         end
         S_DEC: begin
            busy_s  = 1'b1;
            ctrl_s  = CTRL_DECR;
            state_d = S_CHECK;
         end
         S_DONE: begin
            done_s = 1'b1;
            if (Start) state_d = S_CLEAR;
            else       state_d = S_DONE;
         end
         S_ERR: begin
            err_s = 1'b1;
            if (Start) state_d = S_CLEAR;
            else       state_d = S_ERR;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A stalled cycle that would bring the counter up to the limit aborts instead of counting
      if (stall_s && (WAIT_LIMIT != 0)) begin
         if (wait_q == WAIT_LAST) state_d = S_ERR;
         else                     wait_d  = wait_q + WW'(1);
      end else begin
         wait_d = '0;
      end
   end

   // Port drive; Reset forces the idle output pattern immediately
   always_comb begin
      if (Reset) begin
         ACC_Ctrl = CTRL_HOLD;
         In_Ready = 1'b0;
         Busy     = 1'b0;
         Done     = 1'b0;
         Error    = 1'b0;
      end else begin
         ACC_Ctrl = ctrl_s;
         In_Ready = rdy_s;
         Busy     = busy_s;
         Done     = done_s;
         Error    = err_s;
      end
   end

endmodule
